// File: rtl/fft_frame_arbiter_if.sv
// Bundle of the request/grant, sample and FFT-output signals shared between
// the four frame sources, the FFT core and the round-robin frame arbiter.
interface fft_frame_arbiter_if #(
    parameter int DATA_FFT_SIZE = 16
);
    logic [3:0]                   req;
    logic [3:0]                   grant;
    logic [3:0]                   in_valid;
    logic [4*DATA_FFT_SIZE-1:0]   in_data_i;
    logic [4*DATA_FFT_SIZE-1:0]   in_data_q;
    logic                         fft_wayt_data;
    logic                         fft_valid;
    logic [DATA_FFT_SIZE-1:0]     fft_data_i;
    logic [DATA_FFT_SIZE-1:0]     fft_data_q;
    logic                         fft_complete;
    logic [3:0]                   out_complete;
    logic [1:0]                   out_owner;
    logic [3:0]                   done;
    logic                         busy;
    logic                         err_orphan;

    // Arbiter side of the bundle
    modport slave (
        input  req, in_valid, in_data_i, in_data_q, fft_wayt_data, fft_complete,
        output grant, fft_valid, fft_data_i, fft_data_q, out_complete, out_owner,
               done, busy, err_orphan
    );

    // Sources / FFT core side of the bundle
    modport master (
        output req, in_valid, in_data_i, in_data_q, fft_wayt_data, fft_complete,
        input  grant, fft_valid, fft_data_i, fft_data_q, out_complete, out_owner,
               done, busy, err_orphan
    );
endinterface

// File: rtl/fft_frame_arbiter.sv
// Round-robin frame arbiter sharing one FFT core between four frame sources.
// A granted source streams exactly NFFT samples to the core; the owner of each
// loaded frame is queued in a 2-deep FIFO so the FFT output frames can be
// routed back to the source that loaded them.
module fft_frame_arbiter #(
    parameter int SIZE_BUFFER   = 4,
    parameter int DATA_FFT_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_frame_arbiter_if.slave    bus
);

    localparam int NFFT = 1 << SIZE_BUFFER;
    localparam logic [SIZE_BUFFER:0] LAST_IDX = (SIZE_BUFFER+1)'(NFFT - 1);

    typedef enum logic {
        IDLE,
        LOAD
    } loadState_t;

    loadState_t                 state_q;
    logic [3:0]                 grant_q;
    logic [1:0]                 owner_q;
    logic [1:0]                 ptr_q;
    logic [SIZE_BUFFER:0]       cnt_q;
    logic                       fftValid_q;
    logic [DATA_FFT_SIZE-1:0]   fftDataI_q;
    logic [DATA_FFT_SIZE-1:0]   fftDataQ_q;

    logic [1:0]                 fifoMem_q [2];
    logic                       wrPtr_q;
    logic                       rdPtr_q;
    logic [1:0]                 fifoCount_q;
    logic [1:0]                 fifoCount_d;

    logic [SIZE_BUFFER:0]       ocnt_q;
    logic [3:0]                 done_q;
    logic                       errOrphan_q;

    logic                       winnerFound;
    logic [1:0]                 winnerIdx;
    logic [1:0]                 candidate;
    logic                       startGrant;
    logic                       ownerValid;
    logic [DATA_FFT_SIZE-1:0]   ownerDataI;
    logic [DATA_FFT_SIZE-1:0]   ownerDataQ;
    logic                       pushEn;
    logic                       popEn;
    logic                       fifoNonEmpty;
    logic [1:0]                 head;

    assign fifoNonEmpty = (fifoCount_q != 2'd0);
    assign head         = fifoMem_q[rdPtr_q];
    assign ownerValid   = bus.in_valid[owner_q];
    assign ownerDataI   = bus.in_data_i[int'(owner_q)*DATA_FFT_SIZE +: DATA_FFT_SIZE];
    assign ownerDataQ   = bus.in_data_q[int'(owner_q)*DATA_FFT_SIZE +: DATA_FFT_SIZE];

    // Pick the first pending requester scanning upward from the priority pointer
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = ptr_q;
        candidate   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            candidate = ptr_q + 2'(i);
            if (!winnerFound && bus.req[candidate]) begin
                winnerFound = 1'b1;
                winnerIdx   = candidate;
            end
        end
    end

    // A new grant needs an idle core and room for its owner; the count is the pre-pop value
    assign startGrant = (state_q == IDLE) && winnerFound && bus.fft_wayt_data
                        && (fifoCount_q < 2'd2);
    assign pushEn     = (state_q == LOAD) && ownerValid && (cnt_q == LAST_IDX);
    assign popEn      = bus.fft_complete && fifoNonEmpty && (ocnt_q == LAST_IDX);

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        fifoCount_d = fifoCount_q;
        case ({pushEn, popEn})
            2'b10:   fifoCount_d = fifoCount_q + 2'd1;
            2'b01:   fifoCount_d = fifoCount_q - 2'd1;
            default: fifoCount_d = fifoCount_q;
        endcase
    end

    // Load FSM: grant a source, forward its samples (gaps included) until NFFT are taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            owner_q    <= 2'd0;
            ptr_q      <= 2'd0;
            cnt_q      <= '0;
            fftValid_q <= 1'b0;
            fftDataI_q <= '0;
            fftDataQ_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    fftValid_q <= 1'b0;
                    if (startGrant) begin
                        grant_q <= 4'(4'b0001 << winnerIdx);
                        owner_q <= winnerIdx;
                        ptr_q   <= winnerIdx + 2'd1;
                        cnt_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (ownerValid) begin
                        fftValid_q <= 1'b1;
                        fftDataI_q <= ownerDataI;
                        fftDataQ_q <= ownerDataQ;
                        cnt_q      <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            grant_q <= 4'b0000;
                            state_q <= IDLE;
                        end
                    end else begin
                        fftValid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= 4'b0000;
                    fftValid_q <= 1'b0;
                end
            endcase
        end
    end

    // Owner FIFO: record who loaded each frame, release it when its output frame ends
    always_ff @(posedge clk) begin
        if (reset) begin
            fifoMem_q[0] <= 2'd0;
            fifoMem_q[1] <= 2'd0;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            fifoCount_q  <= 2'd0;
        end else begin
            if (pushEn) begin
                fifoMem_q[wrPtr_q] <= owner_q;
                wrPtr_q            <= ~wrPtr_q;
            end
            if (popEn) begin
                rdPtr_q <= ~rdPtr_q;
            end
            fifoCount_q <= fifoCount_d;
        end
    end

    // Output side: count FFT output samples, pulse done for the owner, flag orphan output
    always_ff @(posedge clk) begin
        if (reset) begin
            ocnt_q      <= '0;
            done_q      <= 4'b0000;
            errOrphan_q <= 1'b0;
        end else begin
            done_q      <= 4'b0000;
            errOrphan_q <= 1'b0;
            if (bus.fft_complete) begin
                if (fifoNonEmpty) begin
                    if (ocnt_q == LAST_IDX) begin
                        ocnt_q <= '0;
                        done_q <= 4'(4'b0001 << head);
                    end else begin
                        ocnt_q <= ocnt_q + 1'b1;
                    end
                end else begin
                    errOrphan_q <= 1'b1;
                end
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.fft_valid    = fftValid_q;
    assign bus.fft_data_i   = fftDataI_q;
    assign bus.fft_data_q   = fftDataQ_q;
    assign bus.out_owner    = head;
    assign bus.out_complete = (bus.fft_complete && fifoNonEmpty) ? 4'(4'b0001 << head) : 4'b0000;
    assign bus.done         = done_q;
    assign bus.busy         = (state_q != IDLE) || fifoNonEmpty;
    assign bus.err_orphan   = errOrphan_q;

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: stimulus tasks queue the expected
// FFT samples, done pulses and orphan flags; a negedge monitor pops and
// compares them whenever the arbiter presents one.
module tb_fft_frame_arbiter;

    localparam int SB   = 4;
    localparam int DW   = 16;
    localparam int NFFT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] expSampleQ [$];
    logic [3:0]  expDoneQ   [$];
    int          expOrphan  = 0;
    logic [31:0] expWord;
    logic [3:0]  expDone;

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    fft_frame_arbiter_if #(.DATA_FFT_SIZE(DW)) bus ();

    fft_frame_arbiter #(
        .SIZE_BUFFER   (SB),
        .DATA_FFT_SIZE (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [3:0] oneHot(input int k);
        return 4'(4'b0001 << k);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportUnexpected(input string name, input logic [31:0] actual);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: got %0h, expected nothing at %0t", name, actual, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put sample v on slice k and garbage on every other slice
    task automatic setSample(input int k, input logic [15:0] v);
        bus.in_data_i = {4{16'hDEAD}};
        bus.in_data_q = {4{16'hBEEF}};
        bus.in_data_i[k*DW +: DW] = v;
        bus.in_data_q[k*DW +: DW] = v ^ 16'h5A5A;
    endtask

    // Stream one frame from granted source k, with an optional gap before sample gapAt
    task automatic applyStimulus(input int k, input logic [15:0] base,
                                 input int gapAt, input int gapLen);
        for (int s = 0; s < NFFT; s++) begin
            if (s == gapAt) begin
                for (int g = 0; g < gapLen; g++) begin
                    bus.in_valid = 4'hF & ~oneHot(k);
                    tick();
                    checkOutput("gapGrantHeld", 32'(bus.grant), 32'(oneHot(k)));
                    checkOutput("gapFftValid", 32'(bus.fft_valid), 32'd0);
                end
            end
            setSample(k, base + 16'(s));
            bus.in_valid = 4'hF;
            expSampleQ.push_back({base + 16'(s), (base + 16'(s)) ^ 16'h5A5A});
            tick();
            if (s < NFFT - 1)
                checkOutput("grantHeld", 32'(bus.grant), 32'(oneHot(k)));
        end
        bus.in_valid = 4'h0;
        checkOutput("grantDrop", 32'(bus.grant), 32'd0);
    endtask

    // Feed NFFT FFT output cycles that belong to owner
    task automatic applyDrain(input int owner);
        expDoneQ.push_back(oneHot(owner));
        for (int c = 0; c < NFFT; c++) begin
            bus.fft_complete = 1'b1;
            #1;
            checkOutput("outComplete", 32'(bus.out_complete), 32'(oneHot(owner)));
            checkOutput("outOwner", 32'(bus.out_owner), 32'(owner));
            tick();
            checkOutput("drainNoGrant", 32'(bus.grant), 32'd0);
        end
        bus.fft_complete = 1'b0;
    endtask

    // Scoreboard monitor: compare every presented output against the queued expectation
    always @(negedge clk) begin
        if (bus.fft_valid === 1'b1) begin
            if (expSampleQ.size() == 0) begin
                reportUnexpected("unexpectedSample", {bus.fft_data_i, bus.fft_data_q});
            end else begin
                expWord = expSampleQ.pop_front();
                checkOutput("fftSample", {bus.fft_data_i, bus.fft_data_q}, expWord);
            end
        end
        if (bus.done !== 4'b0000) begin
            if (expDoneQ.size() == 0) begin
                reportUnexpected("unexpectedDone", 32'(bus.done));
            end else begin
                expDone = expDoneQ.pop_front();
                checkOutput("donePulse", 32'(bus.done), 32'(expDone));
            end
        end
        if (bus.err_orphan === 1'b1) begin
            if (expOrphan == 0) begin
                reportUnexpected("unexpectedOrphan", 32'd1);
            end else begin
                expOrphan--;
                checkOutput("errOrphan", 32'(bus.err_orphan), 32'd1);
            end
        end
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        bus.req           = 4'h0;
        bus.in_valid      = 4'h0;
        bus.in_data_i     = '0;
        bus.in_data_q     = '0;
        bus.fft_wayt_data = 1'b0;
        bus.fft_complete  = 1'b0;

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        checkOutput("rstGrant", 32'(bus.grant), 32'd0);
        checkOutput("rstFftValid", 32'(bus.fft_valid), 32'd0);
        checkOutput("rstFftData", {bus.fft_data_i, bus.fft_data_q}, 32'd0);
        checkOutput("rstDone", 32'(bus.done), 32'd0);
        checkOutput("rstOrphan", 32'(bus.err_orphan), 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstOwner", 32'(bus.out_owner), 32'd0);
        checkOutput("rstOutComplete", 32'(bus.out_complete), 32'd0);
        reset = 1'b0;
        tick();

        // Single requester 0, samples 0..15
        $display("[TB] single requester");
        bus.req           = 4'b0001;
        bus.fft_wayt_data = 1'b1;
        tick();
        checkOutput("singleGrant", 32'(bus.grant), 32'b0001);
        bus.req = 4'b0000;
        applyStimulus(0, 16'h0000, -1, 0);
        checkOutput("singleBusy", 32'(bus.busy), 32'd1);
        applyDrain(0);
        checkOutput("singleIdle", 32'(bus.busy), 32'd0);

        // Orphan FFT output with empty FIFO
        $display("[TB] orphan");
        bus.fft_complete = 1'b1;
        #1;
        checkOutput("orphanOutComplete", 32'(bus.out_complete), 32'd0);
        expOrphan++;
        tick();
        bus.fft_complete = 1'b0;
        tick();
        checkOutput("orphanPulseEnd", 32'(bus.err_orphan), 32'd0);
        checkOutput("orphanNoDone", 32'(bus.done), 32'd0);

        // Reset during LOAD at sample 7 of requester 2 (pointer is 1 here)
        $display("[TB] reset mid-frame");
        bus.req = 4'b0100;
        tick();
        checkOutput("rstLoadGrant", 32'(bus.grant), 32'b0100);
        bus.req = 4'b0000;
        for (int s = 0; s < 7; s++) begin
            setSample(2, 16'h0A00 + 16'(s));
            bus.in_valid = 4'hF;
            expSampleQ.push_back({16'h0A00 + 16'(s), (16'h0A00 + 16'(s)) ^ 16'h5A5A});
            tick();
        end
        setSample(2, 16'h0A07);
        bus.in_valid = 4'hF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 4'h0;
        checkOutput("rstLoadGrantClr", 32'(bus.grant), 32'd0);
        checkOutput("rstLoadFftValid", 32'(bus.fft_valid), 32'd0);
        checkOutput("rstLoadBusy", 32'(bus.busy), 32'd0);

        // Round-robin with all four requesting; pointer restarts at 0
        $display("[TB] round robin");
        bus.req = 4'b1111;
        tick();
        checkOutput("rrGrant0", 32'(bus.grant), 32'b0001);
        applyStimulus(0, 16'h0100, -1, 0);
        tick();
        checkOutput("rrGrant1", 32'(bus.grant), 32'b0010);
        applyStimulus(1, 16'h0200, -1, 0);
        for (int w = 0; w < 3; w++) begin
            tick();
            checkOutput("fifoFullNoGrant", 32'(bus.grant), 32'd0);
        end
        applyDrain(0);
        tick();
        checkOutput("rrGrant2", 32'(bus.grant), 32'b0100);
        applyStimulus(2, 16'h0300, -1, 0);
        applyDrain(1);
        tick();
        checkOutput("rrGrant3", 32'(bus.grant), 32'b1000);
        applyStimulus(3, 16'h0400, -1, 0);
        applyDrain(2);
        tick();
        checkOutput("rrGrantWrap", 32'(bus.grant), 32'b0001);
        bus.req = 4'b0000;
        applyStimulus(0, 16'h0500, -1, 0);
        applyDrain(3);
        applyDrain(0);
        checkOutput("rrIdle", 32'(bus.busy), 32'd0);

        // Requester 2 with a 3-cycle in_valid gap before sample 5
        $display("[TB] gaps");
        bus.req = 4'b0100;
        tick();
        checkOutput("gapGrant", 32'(bus.grant), 32'b0100);
        bus.req = 4'b0000;
        applyStimulus(2, 16'h0600, 5, 3);
        applyDrain(2);
        checkOutput("gapIdle", 32'(bus.busy), 32'd0);

        repeat (3) tick();
        checkOutput("samplesLeft", 32'(expSampleQ.size()), 32'd0);
        checkOutput("donesLeft", 32'(expDoneQ.size()), 32'd0);
        checkOutput("orphansLeft", 32'(expOrphan), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fft_frame_arbiter.md
# fft_frame_arbiter

Round-robin scheduler that shares one small FFT core (the radix-4 core fed by the data-to-sFFT interconnect) between four frame sources. It grants one requester at a time, forwards exactly NFFT samples of that frame to the core, and records the owner of each loaded frame in a 2-deep owner FIFO. FFT output frames are tagged back to the requester that loaded them, with a per-requester done pulse.

## Interface
Parameters:
- SIZE_BUFFER, 4, log2(NFFT); frame length NFFT = 2**SIZE_BUFFER.
- DATA_FFT_SIZE, 16, sample width per I/Q component.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  4  req[k]=1: requester k holds a complete frame ready to stream.
- grant  out  4  one-hot; grant[k]=1: requester k may stream samples.
- in_valid  in  4  per-requester sample strobe; honoured only while the matching grant bit is 1.
- in_data_i  in  4*DATA_FFT_SIZE  packed I samples; slice k = [k*DATA_FFT_SIZE +: DATA_FFT_SIZE].
- in_data_q  in  4*DATA_FFT_SIZE  packed Q samples, same packing.
- fft_wayt_data  in  1  FFT core is idle and can take a new frame.
- fft_valid  out  1  sample strobe to the FFT core.
- fft_data_i  out  DATA_FFT_SIZE  I sample to the FFT core.
- fft_data_q  out  DATA_FFT_SIZE  Q sample to the FFT core.
- fft_complete  in  1  FFT output sample strobe; high for NFFT cycles per frame.
- out_complete  out  4  fft_complete routed to the owner of the current output frame.
- out_owner  out  2  index of the owner of the current output frame (FIFO head).
- done  out  4  one-cycle pulse on the owner bit after its last output sample.
- busy  out  1  1 when state is not IDLE or the owner FIFO is non-empty.
- err_orphan  out  1  one-cycle pulse when fft_complete arrives with the owner FIFO empty.

## Operation
- Load FSM states:
  - IDLE -> LOAD when |req && fft_wayt_data && fifo_count<2.
  - On that edge: grant <= one-hot of the winner; sample counter cnt <= 0.
  - The winner is the first set req bit scanning from the priority pointer ptr upward, modulo 4; then ptr <= winner+1 (mod 4).
- LOAD:
  - Each cycle with in_valid[owner]=1: fft_valid <= 1, fft_data <= that requester's slice, cnt <= cnt+1.
  - A cycle with in_valid[owner]=0 gives fft_valid <= 0 and cnt holds (gaps are forwarded, not aborted).
  - On the valid sample with cnt==NFFT-1: push owner into the FIFO, grant <= 0, state -> IDLE.
  - At least one IDLE cycle separates consecutive grants.
- in_valid bits whose grant bit is 0 are ignored. req is not re-checked during LOAD; a requester dropping req mid-frame does not end the grant.
- fft_wayt_data is sampled only in IDLE.
- Output side (runs independently of the load FSM):
  - out_owner = FIFO head.
  - out_complete = fft_complete ? (1 << head) : 0, combinational, gated by fifo_count>0.
  - Output counter ocnt counts fft_complete cycles. On the NFFT-th cycle: done[head] <= 1 for one cycle, FIFO pops, ocnt <= 0.
  - fft_complete with an empty FIFO pulses err_orphan; ocnt is unchanged.
- Push and pop on the same edge are both performed; fifo_count is unchanged.
- fft_data_i/q pass through the arbiter unmodified; there is no arithmetic. Counter widths are SIZE_BUFFER+1 bits.

## Timing
- Reset values: grant=0, fft_valid=0, fft_data_i/q=0, done=0, err_orphan=0, busy=0, ptr=0, FIFO empty, out_owner=0, state IDLE.
- Reset asserted mid-frame clears everything on that edge. A partially loaded frame is discarded and not pushed.
- Grant latency: request condition true at edge n gives grant visible after edge n.
- Data latency: in_valid/in_data at edge m gives fft_valid/fft_data visible after edge m (1 register).
- Grant drop: the last sample is accepted at edge e; grant=0 after e. Earliest next grant is after edge e+1.
- done: asserted the cycle after the NFFT-th fft_complete cycle; out_complete itself has 0 latency.
- FIFO full (2 frames outstanding): no new grant until a pop. A pop and a grant decision on the same edge use the pre-pop count.

## Test plan
- Single requester: req=4'b0001, fft_wayt_data=1, stream 16 contiguous samples 0..15. Expect grant=0001 for 16 valid cycles, fft_data 0..15 one cycle late, FIFO count 1. Then 16 fft_complete cycles: out_complete=0001, done[0] pulse.
- Round-robin: req=4'b1111 held. Expect grant order 0,1,2,3,0 with one IDLE cycle between frames, and ptr wrapping 3->0.
- Gaps: requester 2 drops in_valid for 3 cycles mid-frame. Expect fft_valid gaps that match, grant held, exactly 16 samples forwarded.
- FIFO full: two frames loaded, no fft_complete, req pending. Expect no third grant. The first done pops the FIFO, and a grant follows on a later edge.
- Orphan: fft_complete pulsed with the FIFO empty. Expect an err_orphan pulse, out_complete=0, done=0.
- Reset during LOAD at sample 7: expect grant=0 and fft_valid=0 after the edge, FIFO empty, ptr=0, and no done ever for that frame.
